// File: rtl/rsa_host_ctrl.sv
// Byte-stream front end for the 256-bit RSA modexp core: loads operands, runs the core, streams the result.
// Optional busy-wait watchdog compiled in with `define RSA_CTRL_TIMEOUT_EN.
module rsa_host_ctrl #(
    parameter int NBYTES         = 32,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       done,
    output logic       err,
    output logic       core_rst,
    output logic       core_start,
    output logic       core_we_n,
    output logic       core_oe_n,
    output logic [1:0] core_reg_sel,
    output logic [5:0] core_addr,
    output logic [7:0] core_data_o,
    input  logic [7:0] core_data_i,
    input  logic       core_busy
);

    typedef enum logic [3:0] {
        LOAD, CLEAR, LAUNCH, WAIT_HI, WAIT_LO, RD_REQ, RD_CAP, SEND, ERR
    } state_t;

    localparam logic [6:0] NB1   = 7'(NBYTES);
    localparam logic [6:0] NB2   = 7'(2 * NBYTES);
    localparam logic [6:0] NB3M1 = 7'(3 * NBYTES - 1);
    localparam logic [6:0] NBM1  = 7'(NBYTES - 1);

    state_t     state;
    logic [6:0] cnt;
    logic [1:0] clr_cnt;
    logic       tmo_hit;

    assign done = ~reset & (state == SEND) & out_ready & (cnt == NBM1);

`ifdef RSA_CTRL_TIMEOUT_EN
    logic [31:0] tmo;
    logic        err_q;

    assign tmo_hit = ((state == WAIT_HI) || (state == WAIT_LO))
                   && (tmo == 32'(TIMEOUT_CYCLES - 1));
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == LAUNCH)
                tmo <= '0;
            else if ((state == WAIT_HI) || (state == WAIT_LO))
                tmo <= tmo + 32'd1;
            if (tmo_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            clr_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == NB3M1) begin
                            cnt     <= '0;
                            clr_cnt <= '0;
                            state   <= CLEAR;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 2'd1;
                    if (clr_cnt == 2'd3)
                        state <= LAUNCH;
                end
                LAUNCH: state <= WAIT_HI;
                WAIT_HI: begin
                    if (tmo_hit)
                        state <= ERR;
                    else if (core_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (tmo_hit)
                        state <= ERR;
                    else if (!core_busy)
                        state <= RD_REQ;
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    out_data  <= core_data_i;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == NBM1) begin
                            cnt   <= '0;
                            state <= LOAD;
                        end else begin
                            cnt   <= cnt + 7'd1;
                            state <= RD_REQ;
                        end
                    end
                end
                ERR: state <= ERR;
                default: state <= LOAD;
            endcase
        end
    end

    // Strobes are forced idle while reset is held, not just after it.
    always_comb begin
        in_ready     = 1'b0;
        core_we_n    = 1'b1;
        core_oe_n    = 1'b1;
        core_start   = 1'b1;
        core_rst     = 1'b0;
        core_reg_sel = 2'd0;
        core_addr    = 6'd0;
        core_data_o  = 8'd0;
        if (!reset) begin
            unique case (state)
                LOAD: begin
                    in_ready    = 1'b1;
                    core_we_n   = ~in_valid;
                    core_data_o = in_data;
                    if (cnt < NB1) begin
                        core_reg_sel = 2'd3;
                        core_addr    = cnt[5:0];
                    end else if (cnt < NB2) begin
                        core_reg_sel = 2'd1;
                        core_addr    = 6'(cnt - NB1);
                    end else begin
                        core_reg_sel = 2'd2;
                        core_addr    = 6'(cnt - NB2);
                    end
                end
                CLEAR:  core_rst = ~clr_cnt[1];
                LAUNCH: core_start = 1'b0;
                RD_REQ: begin
                    core_oe_n    = 1'b0;
                    core_reg_sel = 2'd0;
                    core_addr    = cnt[5:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Bench for rsa_host_ctrl: behavioural modexp core, directed vector table and randomized operand runs.
module tb_rsa_host_ctrl;

    localparam int NB = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, done, err;
    logic [7:0] out_data, core_data_o;
    logic       core_rst, core_start, core_we_n, core_oe_n;
    logic [1:0] core_reg_sel;
    logic [5:0] core_addr;
    logic [7:0] core_data_i = 8'd0;
    logic       core_busy = 1'b0;

    always #5 clk = ~clk;

    rsa_host_ctrl #(.NBYTES(NB), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .done(done), .err(err),
        .core_rst(core_rst), .core_start(core_start),
        .core_we_n(core_we_n), .core_oe_n(core_oe_n),
        .core_reg_sel(core_reg_sel), .core_addr(core_addr),
        .core_data_o(core_data_o), .core_data_i(core_data_i),
        .core_busy(core_busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic bit [63:0] modexp(bit [63:0] b, bit [63:0] e, bit [63:0] m);
        bit [63:0] r;
        r = 64'd1 % m;
        b = b % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    // Behavioural core: byte register file, modexp on start, busy after a delay.
    logic [7:0]  cm_mem [4][NB];
    bit   [63:0] cm_r = 64'd0;
    int          cm_phase = 0;
    int          cm_cnt = 0;
    int          bdelay = 3;
    int          bhold = 50;
    bit          stuck = 1'b0;

    function automatic bit [63:0] opnd(int s);
        bit [63:0] v = 64'd0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = cm_mem[s][k];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!core_we_n) cm_mem[core_reg_sel][core_addr[4:0]] <= core_data_o;
        if (!core_oe_n) core_data_i <= 8'(cm_r >> (8 * core_addr));
        if (core_rst) begin
            cm_phase  <= 0;
            core_busy <= 1'b0;
        end else if (!core_start) begin
            cm_r     <= modexp(opnd(1), opnd(2), opnd(3));
            cm_phase <= 1;
            cm_cnt   <= 1;
        end else if (cm_phase == 1) begin
            if (cm_cnt >= bdelay - 1) begin
                core_busy <= 1'b1;
                cm_phase  <= 2;
                cm_cnt    <= 1;
            end else cm_cnt <= cm_cnt + 1;
        end else if (cm_phase == 2 && !stuck) begin
            if (cm_cnt >= bhold) begin
                core_busy <= 1'b0;
                cm_phase  <= 0;
            end else cm_cnt <= cm_cnt + 1;
        end
    end

    // Passive monitor, sampled mid-cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] wr_sel[$];
    logic [5:0] wr_addr[$];
    int bad_wr = 0, rd_req = 0, done_cnt = 0;
    int rst_run = 0, last_rst_hi = 0, start_run = 0, start_cyc = 0;
    int busy_fall = 0, first_oe = 0, ov_rise = 0, err_cyc = -1;
    bit oe_seen = 0, ov_seen = 0;
    bit p_busy = 0, p_rst = 0, p_slo = 0, p_err = 0, p_ov = 0;

    always @(negedge clk) begin
        if (!core_busy && p_busy) begin
            busy_fall = cyc;
            oe_seen = 0;
            ov_seen = 0;
        end
        if (!core_we_n) begin
            wr_sel.push_back(core_reg_sel);
            wr_addr.push_back(core_addr);
            if (!in_valid) bad_wr++;
        end
        if (!core_oe_n) begin
            rd_req++;
            if (!oe_seen) begin oe_seen = 1; first_oe = cyc; end
        end
        if (out_valid && !p_ov && !ov_seen) begin ov_seen = 1; ov_rise = cyc; end
        if (done) done_cnt++;
        if (core_rst) begin
            rst_run = p_rst ? rst_run + 1 : 1;
            last_rst_hi = cyc;
        end
        if (!core_start) begin
            start_run = p_slo ? start_run + 1 : 1;
            start_cyc = cyc;
        end
        if (err && !p_err) err_cyc = cyc;
        p_busy = core_busy; p_rst = core_rst; p_slo = !core_start;
        p_err = err; p_ov = out_valid;
    end

    task automatic check(input string nm, input bit [63:0] act, input bit [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input bit [63:0] m, input bit [63:0] b, input bit [63:0] e,
                              input int n, input bit gaps);
        bit [63:0] v;
        int k;
        for (int i = 0; i < n; i++) begin
            k = i % NB;
            v = (i < NB) ? m : (i < 2 * NB) ? b : e;
            if (gaps) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = (k < 8) ? 8'(v >> (8 * k)) : 8'h00;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input bit [63:0] m, input bit [63:0] b,
                          input bit [63:0] e, input bit [63:0] req, input bit gaps,
                          input int stall_idx);
        int w0, r0, d0, bw0, idx, budget, stall_n, bad_bytes, order_bad, rs;
        bit to, stall_bad;
        logic [7:0] sd;
        logic [7:0] got [NB];
        w0 = wr_sel.size(); r0 = rd_req; d0 = done_cnt; bw0 = bad_wr;
        load_bytes(m, b, e, 3 * NB, gaps);
        idx = 0; budget = 0; stall_n = 0; to = 0; stall_bad = 0; sd = 8'd0; rs = 0;
        out_ready = (stall_idx != 0);
        while (idx < NB) begin
            @(negedge clk);
            if (++budget > 5000) begin to = 1; break; end
            if (out_valid && out_ready) begin
                if (idx == stall_idx && (stall_n != 10 || out_data !== sd || rd_req != rs))
                    stall_bad = 1;
                got[idx] = out_data;
                idx++;
            end else if (out_valid) begin
                if (stall_n == 0) begin sd = out_data; rs = rd_req; end
                else if (out_data !== sd) stall_bad = 1;
                stall_n++;
            end
            step();
            out_ready = !(idx == stall_idx && stall_n < 10);
        end
        out_ready = 1'b0;
        check({nm, " timeout"}, 64'(to), 64'd0);
        bad_bytes = 0;
        for (int i = 0; i < idx; i++)
            if (got[i] !== ((i < 8) ? 8'(req >> (8 * i)) : 8'h00)) bad_bytes++;
        check({nm, " result bytes wrong"}, 64'(bad_bytes), 64'd0);
        check({nm, " done pulses"}, 64'(done_cnt - d0), 64'd1);
        check({nm, " core writes"}, 64'(wr_sel.size() - w0), 64'(3 * NB));
        order_bad = 0;
        for (int i = 0; i < 3 * NB && w0 + i < wr_sel.size(); i++) begin
            if (wr_sel[w0 + i] != ((i < NB) ? 2'd3 : (i < 2 * NB) ? 2'd1 : 2'd2)) order_bad++;
            if (wr_addr[w0 + i] != 6'(i % NB)) order_bad++;
        end
        check({nm, " write order"}, 64'(order_bad), 64'd0);
        check({nm, " write without in_valid"}, 64'(bad_wr - bw0), 64'd0);
        check({nm, " read requests"}, 64'(rd_req - r0), 64'(NB));
        if (stall_idx >= 0 && stall_idx < NB)
            check({nm, " stall hold"}, 64'(stall_bad), 64'd0);
    endtask

    typedef struct {
        bit [63:0] m;
        bit [63:0] b;
        bit [63:0] e;
        bit [63:0] req;
        bit        gaps;
        int        stall;
    } vec_t;

    vec_t vt[7];

    initial begin
        bit [63:0] m, b, e;
        int w0, budget;
        vt[0] = '{64'd187,   64'd88, 64'd7,  64'h0B,     1'b0, -1};
        vt[1] = '{64'd187,   64'd88, 64'd7,  64'h0B,     1'b1, -1};
        vt[2] = '{64'd187,   64'd88, 64'd7,  64'h0B,     1'b0, 5};
        vt[3] = '{64'd33,    64'd4,  64'd3,  64'd31,     1'b0, -1};
        vt[4] = '{64'd65537, 64'd2,  64'd16, 64'h10000,  1'b1, -1};
        vt[5] = '{64'd13,    64'd2,  64'd10, 64'd10,     1'b0, 0};
        vt[6] = '{64'd256,   64'd3,  64'd5,  64'hF3,     1'b0, 31};

        repeat (3) step();
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle in_ready", 64'(in_ready), 64'd1);
        check("idle strobes", {60'd0, core_we_n, core_oe_n, core_start, core_rst}, 64'hE);
        step();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].m, vt[i].b, vt[i].e, vt[i].req,
                   vt[i].gaps, vt[i].stall);
            if (i == 0) begin
                check("core_rst high cycles", 64'(rst_run), 64'd2);
                check("core_start low cycles", 64'(start_run), 64'd1);
                check("start after rst fall", 64'(start_cyc - last_rst_hi), 64'd3);
                check("rd_req after busy fall", 64'(first_oe - busy_fall), 64'd1);
                check("out_valid after rd_req", 64'(ov_rise - first_oe), 64'd2);
            end
        end

        // Abort a load part way, then reload from scratch.
        load_bytes(64'hDEAD, 64'hBEEF, 64'h55, 40, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        @(negedge clk);
        check("write during reset", 64'(core_we_n), 64'd1);
        check("in_ready during reset", 64'(in_ready), 64'd0);
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        w0 = wr_sel.size();
        run_op("reload", 64'd187, 64'd88, 64'd7, 64'h0B, 1'b0, -1);
        check("reload first sel/addr", {56'd0, wr_sel[w0], wr_addr[w0]}, {56'd0, 2'd3, 6'd0});

        for (int i = 0; i < 6; i++) begin
            m = 64'($urandom);
            if (m < 64'd2) m = 64'd3;
            b = {$urandom, $urandom};
            e = {$urandom, $urandom};
            bdelay = $urandom_range(1, 5);
            bhold = $urandom_range(1, 20);
            run_op($sformatf("rand%0d", i), m, b, e, modexp(b, e, m),
                   1'($urandom_range(0, 1)), $urandom_range(0, 40));
        end
        bdelay = 3;
        bhold = 50;

`ifdef RSA_CTRL_TIMEOUT_EN
        stuck = 1'b1;
        err_cyc = -1;
        load_bytes(64'd187, 64'd88, 64'd7, 3 * NB, 1'b0);
        budget = 0;
        while (!err && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("err raised", 64'(err), 64'd1);
        check("err after wait cycles", 64'(err_cyc - start_cyc), 64'd101);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("in_ready in ERR", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        stuck = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("err cleared", 64'(err), 64'd0);
        check("in_ready after reset", 64'(in_ready), 64'd1);
        step();
        run_op("post-err", 64'd187, 64'd88, 64'd7, 64'h0B, 1'b0, -1);
`else
        @(negedge clk);
        check("err tied low", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_host_ctrl.md
# rsa_host_ctrl

Byte-stream sequencer that sits directly upstream of the 256-bit RSA modular-exponentiation core. It accepts modulus, base and exponent as a flow-controlled byte stream and writes them into the core's byte-addressed register bus. It then resets and launches the core, waits for completion, reads the 32-byte result back, and emits it as a byte stream. It is the only master of the core's bus.

## Interface
- NBYTES, 32: bytes per operand; legal range 1..32; core addr decode is 5-bit.
- TIMEOUT_CYCLES, 2000000: busy-wait limit; used only when the timeout feature is compiled in.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  input byte accepted when in_valid & in_ready
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- out_ready  in  1  downstream accepts result byte
- done  out  1  one-cycle pulse on acceptance of the last result byte
- err  out  1  sticky timeout flag
- core_rst  out  1  core reset
- core_start  out  1  core start; active-low launch pulse, idles high
- core_we_n  out  1  core write strobe, active-low
- core_oe_n  out  1  core read strobe, active-low
- core_reg_sel  out  2  3 = modulus, 1 = base, 2 = exponent, 0 = result
- core_addr  out  6  byte index, LSB byte = 0
- core_data_o  out  8  write data to core
- core_data_i  in  8  core read data, registered inside the core; valid one cycle after the strobe
- core_busy  in  1  core ready/busy flag, high while computing

## Operation
- **States:** LOAD, CLEAR, LAUNCH, WAIT_HI, WAIT_LO, RD_REQ, RD_CAP, SEND, ERR.
- **Byte counter `cnt`:** 7-bit. It counts 0..3·NBYTES-1 in LOAD and 0..NBYTES-1 in the read phase.

**LOAD**
- in_ready = 1.
- Writes are combinational: core_we_n = ~in_valid, core_data_o = in_data, core_addr = cnt mod NBYTES.
- core_reg_sel = 3 for cnt < NBYTES, 1 for cnt < 2·NBYTES, otherwise 2.
- Byte order is LSB first: modulus, then base, then exponent.
- Each accepted byte increments cnt.
- After the byte at cnt = 3·NBYTES-1 is accepted: cnt <= 0, go to CLEAR.

**CLEAR (4 cycles)**
- core_rst = 1 in cycles 0-1 and 0 in cycles 2-3. This satisfies the core's two-flop reset synchroniser.
- Then go to LAUNCH.

**LAUNCH (1 cycle)**
- core_start = 0, then go to WAIT_HI.

**WAIT_HI / WAIT_LO**
- WAIT_HI waits for core_busy = 1, then goes to WAIT_LO.
- WAIT_LO waits for core_busy = 0, then goes to RD_REQ.

**Read phase**
- RD_REQ: core_oe_n = 0, core_reg_sel = 0, core_addr = cnt.
- RD_CAP: out_data <= core_data_i, out_valid <= 1, go to SEND.
- SEND: hold out_data and out_valid until out_ready.
  - On handshake with cnt < NBYTES-1: cnt++, go to RD_REQ.
  - On handshake with cnt = NBYTES-1: done = 1 for that cycle, cnt <= 0, go to LOAD.

**ERR**
- All strobes are inactive and in_ready = 0.
- The only exit is reset.

**Default outside the listed cases:** core_we_n = core_oe_n = 1, core_start = 1, core_rst = 0, in_ready = 0.

**Reset**
- In any state, reset clears everything: state LOAD, cnt 0, out_valid 0, out_data 0, done 0, err 0.
- Core strobes return to their defaults the same cycle.
- A partially loaded operand set is discarded; the next stream starts at modulus byte 0.

## Timing
- Load: 3·NBYTES cycles minimum, one byte per cycle at full in_valid rate. Back-pressure is only via in_valid gaps.
- Overhead: CLEAR (4) + LAUNCH (1) + at least 1 cycle in WAIT_HI.
- Read: 3 cycles per byte minimum (RD_REQ, RD_CAP, SEND). First out_valid rises 2 cycles after WAIT_LO exits.
- out_data and out_valid are registered. in_ready and the core write strobes are combinational from state and in_valid.
- out_valid never drops without a handshake.
- in_valid is ignored outside LOAD.

## Configuration
- **RSA_CTRL_TIMEOUT_EN defined:**
  - A 32-bit counter clears on LAUNCH and increments in WAIT_HI and WAIT_LO.
  - When it reaches TIMEOUT_CYCLES: go to ERR and set err = 1.
- **RSA_CTRL_TIMEOUT_EN undefined:**
  - No counter; waits are unbounded.
  - err is tied to 0 and ERR is unreachable.

## Test plan
- NBYTES = 32, modulus 187, base 88, exponent 7, all other bytes 0, with a behavioral core model. Required response:
  - out bytes are 0x0B followed by 31 bytes of 0x00;
  - done pulses once;
  - exactly 96 core writes occur, with reg_sel sequence 3, 1, 2.
- Same operands with in_valid toggling every other cycle: identical result, and no core write on cycles with in_valid = 0.
- out_ready held low for 10 cycles on byte 5: out_data stays stable with out_valid high, and no extra RD_REQ is issued.
- Reset asserted after 40 input bytes, then a full 96-byte reload of the scenario-1 operands: result 0x0B, and the first post-reset write has reg_sel = 3, addr = 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 100, core_busy stuck at 1): err rises after 100 wait cycles, in_ready stays 0 until reset, then clears.
- Core model raising busy 3 cycles after the start pulse and holding it 50 cycles:
  - core_rst is high exactly 2 cycles, with core_start = 0 exactly 1 cycle, 2 cycles after core_rst falls;
  - the first RD_REQ occurs the cycle after busy falls.
